// File: rtl/xor_frame_checksum.sv
// xor_frame_checksum: folds a valid/ready frame of words into an XOR checksum and word count.
// Optional XOR_CHK_COMPARE_EN adds exp_sum input and out_err mismatch flag.
module xor_frame_checksum #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0]  out_count
`ifdef XOR_CHK_COMPARE_EN
  ,
  input  logic [DATA_WIDTH-1:0] exp_sum,
  output logic                  out_err
`endif
);
  typedef enum logic [1:0] {IDLE = 2'b00, ACC = 2'b01, HOLD = 2'b10} state_t;
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_acc, w_acc, w_base, w_fold;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt, w_inc;
  logic                  w_accept, w_done, w_rel;
  assign w_accept = in_valid & in_ready & (r_state == IDLE || r_state == ACC);
  assign w_done   = w_accept & in_last;
  assign w_rel    = (r_state == HOLD) & out_valid & out_ready;
  assign w_base   = (r_state == ACC) ? r_acc : '0;
  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_xor
    assign w_fold[b] = w_base[b] ^ in_data[b];
  end
  // counter sticks at all-ones once saturated
  assign w_inc = (r_state == IDLE) ? CNT_WIDTH'(1) : (&r_cnt ? r_cnt : r_cnt + CNT_WIDTH'(1));
  always_comb begin
    w_next = r_state;
    w_acc  = r_acc;
    w_cnt  = r_cnt;
    case (r_state)
      IDLE, ACC: if (w_accept) begin
        w_acc  = w_fold;
        w_cnt  = w_inc;
        w_next = in_last ? HOLD : ACC;
      end
      HOLD: if (w_rel) begin
        w_acc  = '0;
        w_cnt  = '0;
        w_next = IDLE;
      end
      default: begin
        w_acc  = '0;
        w_cnt  = '0;
        w_next = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      r_state   <= w_next;
      r_acc     <= w_acc;
      r_cnt     <= w_cnt;
      in_ready  <= (w_next != HOLD);
      out_valid <= (w_next == HOLD);
      out_sum   <= w_done ? w_fold : out_sum;
      out_count <= w_done ? w_inc : out_count;
    end
  end
`ifdef XOR_CHK_COMPARE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_err <= 1'b0;
    else if (w_done) out_err <= (w_fold != exp_sum);
  end
`endif
endmodule

// File: tb/tb_xor_frame_checksum.sv
// tb_xor_frame_checksum: directed checks of xor_frame_checksum, plus a CNT_WIDTH=2 instance for saturation.
module tb_xor_frame_checksum;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, s_in_ready, s_out_valid;
  logic [7:0] out_sum, s_out_sum, out_count;
  logic [1:0] s_out_count;
  int         checks = 0, failures = 0;
`ifdef XOR_CHK_COMPARE_EN
  logic [7:0] exp_sum = '0;
  logic       out_err, s_out_err;
`endif

  always #5 clk = ~clk;

  xor_frame_checksum #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
`ifdef XOR_CHK_COMPARE_EN
    , .exp_sum(exp_sum), .out_err(out_err)
`endif
  );

  xor_frame_checksum #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_sum(s_out_sum), .out_count(s_out_count)
`ifdef XOR_CHK_COMPARE_EN
    , .exp_sum(exp_sum), .out_err(s_out_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one word at a falling edge; it is accepted on the following rising edge
  task automatic send(input logic [7:0] d, input logic l);
    chk("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_handshake", out_valid, 0);
    chk("in_ready_after_handshake", in_ready, 1);
  endtask

  initial begin
    // 1: reset state and release
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    rst_n = 1'b1;
    #1 chk("in_ready_before_first_edge", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_release", in_ready, 1);

    // 2: three-word frame, result visible one edge after last accept
    send(8'h12, 0);
    send(8'h34, 0);
    chk("out_valid_mid_frame", out_valid, 0);
    send(8'h56, 1);
    chk("f2_out_valid", out_valid, 1);
    chk("f2_out_sum", out_sum, 8'h70);
    chk("f2_out_count", out_count, 3);
    chk("f2_in_ready_hold", in_ready, 0);
    chk("f2_sat_count", s_out_count, 3);
    release_result();

    // 3: single-word frame
    send(8'hA5, 1);
    chk("f3_out_sum", out_sum, 8'hA5);
    chk("f3_out_count", out_count, 1);

    // 4: back-pressure with ignored input pulses
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h3C + 8'(i);
      in_last  = i[0];
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_sum", out_sum, 8'hA5);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_out_count", out_count, 1);
    release_result();
    send(8'h0F, 1);
    chk("post_bp_sum", out_sum, 8'h0F);
    chk("post_bp_count", out_count, 1);
    release_result();

    // 5: reset mid-frame discards partial result
    send(8'h11, 0);
    send(8'h22, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_valid", out_valid, 0);
    send(8'hFF, 1);
    chk("f5_out_sum", out_sum, 8'hFF);
    chk("f5_out_count", out_count, 1);
    release_result();

    // 5b: count saturation on the CNT_WIDTH=2 instance
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h04, 0);
    send(8'h08, 0);
    send(8'h10, 1);
    chk("sat_out_sum", out_sum, 8'h1F);
    chk("sat_full_count", out_count, 5);
    chk("sat_count", s_out_count, 3);
    chk("sat_sum", s_out_sum, 8'h1F);
    release_result();

`ifdef XOR_CHK_COMPARE_EN
    // 6: expected-checksum comparison
    exp_sum = 8'h70;
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'h56, 1);
    chk("cmp_match_err", out_err, 0);
    release_result();
    exp_sum = 8'h71;
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'h56, 1);
    chk("cmp_mismatch_err", out_err, 1);
    release_result();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
